ysyx_24100029_idex_reg: RTL and testbench
=========================================

YSYX_24100029_IDEX_REG -- requirements
Module: ysyx_24100029_idex_reg

Interface
REQ-001 SHALL have parameter BW, default 32; this is the datapath width shared with the ALU.
REQ-002 SHALL have port clock, input, 1 bit; the single clock, with all state updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1); the decode-side handshake.
REQ-005 SHALL have ports in_pc, in_rs1_data, in_rs2_data and in_imm, each input, BW bits; the decoded operands.
REQ-006 SHALL have ports in_rs1_idx, in_rs2_idx and in_rd, each input, 5 bits; the register indices.
REQ-007 SHALL have ports in_rd_wen (input, 1) and in_alu_choice (input, 4); the ALU opcode, drawn from the shared alu_* codes.
REQ-008 SHALL have ports in_src1_sel and in_src2_sel, each input, 2 bits; the operand-select codes.
REQ-009 SHALL have ports fwd_wen (input, 1), fwd_rd (input, 5) and fwd_data (input, BW); the writeback forwarding port.
REQ-010 SHALL have port flush, input, 1 bit; kills the held instruction.
REQ-011 SHALL have ports out_valid (input side of handshake is out_ready, input, 1; out_valid is output, 1); the execute-side handshake.
REQ-012 SHALL have ports alu_d1, alu_d2 and out_store_data, each output, BW bits; the ALU operands and the rs2 value for stores.
REQ-013 SHALL have ports out_alu_choice (4), out_rd (5), out_rd_wen (1) and out_pc (BW), all outputs; the forwarded control fields.
REQ-014 SHALL have port stall_cnt, output, 32 bits; counts cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL be a single-entry pipeline register with in_ready = !out_valid || out_ready, computed combinationally.
REQ-016 SHALL accept an input transfer when in_valid && in_ready; the fields are captured at that edge and out_valid=1 the next cycle, giving 1-cycle latency.
REQ-017 SHALL clear out_valid on an output transfer (out_valid && out_ready) that has no simultaneous accept.
REQ-018 SHALL, when an output transfer and an accept occur in the same cycle, load the new entry with out_valid staying 1; there is no bubble.
REQ-019 SHALL give flush priority over accept: out_valid=0 at the next edge, and any simultaneous input is discarded.
REQ-020 SHALL leave stall_cnt unchanged on flush.
REQ-021 SHALL apply capture-time forwarding: if fwd_wen && fwd_rd!=0 && fwd_rd==in_rsX_idx, the captured rsX is fwd_data instead of in_rsX_data.
REQ-022 SHALL apply hold-time forwarding: while out_valid && !out_ready, a matching fwd write (rd!=0) updates the held rs1/rs2 in place.
REQ-023 SHALL never forward to index 0; x0 reads stay as supplied.
REQ-024 SHALL select alu_d1 from the held state: src1_sel 0=rs1, 1=pc, 2=zero, 3=zero.
REQ-025 SHALL select alu_d2 from the held state: src2_sel 0=rs2, 1=imm, 2=constant 4, 3=zero.
REQ-026 SHALL drive out_store_data from the held (forwarded) rs2.
REQ-027 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-028 SHALL increment stall_cnt once per stalled cycle, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL treat output fields as don't-care when out_valid=0, but keep them at their last values (no X).

Reset
REQ-030 SHALL, while reset=1 at an edge, set out_valid=0, stall_cnt=0, and all held fields to 0 (alu_choice 0, sel codes 0).
REQ-031 SHALL give reset priority over flush, accept and forwarding; reset mid-stall drops the entry.
REQ-032 SHALL, during reset, drive in_ready=1 per REQ-015, while ignoring in_valid on that edge.

Structure
REQ-033 SHALL place the src1/src2 select encodings in the shared para definitions, alongside the existing alu_* opcode codes.
REQ-034 SHALL use one sub-module, ysyx_24100029_opsel (combinational operand mux, REQ-024..025), with all state kept in the top level.
REQ-035 SHALL not instantiate the ALU; the downstream execute stage consumes alu_d1, alu_d2 and out_alu_choice.

Verification
REQ-036 SHALL cover basic flow: in_valid=1, rs1=5, imm=7, src1_sel=0, src2_sel=1, out_ready=1 -> next cycle out_valid=1, alu_d1=5, alu_d2=7; out_valid drops after transfer if no new input.
REQ-037 SHALL cover stall plus hold forwarding: held rs2_idx=3, out_ready=0 for 4 cycles, fwd_wen=1 fwd_rd=3 fwd_data=0xDEAD in cycle 2 -> alu_d2=0xDEAD from cycle 3, in_ready=0 throughout, stall_cnt=4.
REQ-038 SHALL cover x0 protection: fwd_wen=1 fwd_rd=0 fwd_data=0xFFFF, in_rs1_idx=0, in_rs1_data=0 -> alu_d1=0.
REQ-039 SHALL cover flush versus accept: flush=1 and in_valid=1 in the same cycle -> out_valid=0 next cycle, and the input is not presented later.
REQ-040 SHALL cover back-to-back transfers: 3 instructions with out_ready=1 every cycle -> out_valid=1 for 3 consecutive cycles with fields in order and no bubbles.
REQ-041 SHALL cover reset mid-stall: out_valid=1, out_ready=0, reset=1 for one edge -> out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/ysyx_24100029_idex_reg_pkg.sv
// Shared decode/execute definitions: ALU opcodes, operand-select encodings and forwarding match helper.
package ysyx_24100029_idex_reg_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;

   localparam logic [1:0] SRC1_RS1   = 2'd0;
   localparam logic [1:0] SRC1_PC    = 2'd1;
   localparam logic [1:0] SRC1_ZERO  = 2'd2;
   localparam logic [1:0] SRC1_ZERO2 = 2'd3;

   localparam logic [1:0] SRC2_RS2   = 2'd0;
   localparam logic [1:0] SRC2_IMM   = 2'd1;
   localparam logic [1:0] SRC2_FOUR  = 2'd2;
   localparam logic [1:0] SRC2_ZERO  = 2'd3;

   // x0 is hard-wired, so a write to it must never override an operand.
   function automatic logic fwd_hit(input logic wen, input logic [4:0] rd, input logic [4:0] idx);
      return wen && (rd != 5'd0) && (rd == idx);
   endfunction

endpackage

// File: rtl/ysyx_24100029_opsel.sv
// Combinational ALU operand selection from the held ID/EX state.
module ysyx_24100029_opsel
   import ysyx_24100029_idex_reg_pkg::*;
#(
   parameter int BW = 32
) (
   input  logic [1:0]    i_src1_sel,
   input  logic [1:0]    i_src2_sel,
   input  logic [BW-1:0] i_rs1,
   input  logic [BW-1:0] i_rs2,
   input  logic [BW-1:0] i_pc,
   input  logic [BW-1:0] i_imm,
   output logic [BW-1:0] o_d1,
   output logic [BW-1:0] o_d2
);

   always_comb begin
      o_d1 = '0;
      case (i_src1_sel)
         SRC1_RS1:   o_d1 = i_rs1;
         SRC1_PC:    o_d1 = i_pc;
         SRC1_ZERO:  o_d1 = '0;
         SRC1_ZERO2: o_d1 = '0;
         default:    o_d1 = '0;
      endcase
   end

   always_comb begin
      o_d2 = '0;
      case (i_src2_sel)
         SRC2_RS2:  o_d2 = i_rs2;
         SRC2_IMM:  o_d2 = i_imm;
         SRC2_FOUR: o_d2 = BW'(4);
         SRC2_ZERO: o_d2 = '0;
         default:   o_d2 = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_24100029_idex_reg.sv
// ID/EX single-entry pipeline register with valid/ready handshake, writeback
// forwarding at capture and while held, flush, and a stall-cycle counter.
module ysyx_24100029_idex_reg
   import ysyx_24100029_idex_reg_pkg::*;
#(
   parameter int BW = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] in_pc,
   input  logic [BW-1:0] in_rs1_data,
   input  logic [BW-1:0] in_rs2_data,
   input  logic [BW-1:0] in_imm,
   input  logic [4:0]    in_rs1_idx,
   input  logic [4:0]    in_rs2_idx,
   input  logic [4:0]    in_rd,
   input  logic          in_rd_wen,
   input  logic [3:0]    in_alu_choice,
   input  logic [1:0]    in_src1_sel,
   input  logic [1:0]    in_src2_sel,
   input  logic          fwd_wen,
   input  logic [4:0]    fwd_rd,
   input  logic [BW-1:0] fwd_data,
   input  logic          flush,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [BW-1:0] alu_d1,
   output logic [BW-1:0] alu_d2,
   output logic [BW-1:0] out_store_data,
   output logic [3:0]    out_alu_choice,
   output logic [4:0]    out_rd,
   output logic          out_rd_wen,
   output logic [BW-1:0] out_pc,
   output logic [31:0]   stall_cnt
);

   logic          r_valid;
   logic [BW-1:0] r_pc;
   logic [BW-1:0] r_rs1;
   logic [BW-1:0] r_rs2;
   logic [BW-1:0] r_imm;
   logic [4:0]    r_rs1_idx;
   logic [4:0]    r_rs2_idx;
   logic [4:0]    r_rd;
   logic          r_rd_wen;
   logic [3:0]    r_alu_choice;
   logic [1:0]    r_src1_sel;
   logic [1:0]    r_src2_sel;
   logic [31:0]   r_stall_cnt;

   logic          w_accept;
   logic          w_fire;
   logic          w_stall;
   logic [BW-1:0] w_cap_rs1;
   logic [BW-1:0] w_cap_rs2;

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_fire   = r_valid && out_ready;
   assign w_stall  = r_valid && !out_ready;

   assign w_cap_rs1 = fwd_hit(fwd_wen, fwd_rd, in_rs1_idx) ? fwd_data : in_rs1_data;
   assign w_cap_rs2 = fwd_hit(fwd_wen, fwd_rd, in_rs2_idx) ? fwd_data : in_rs2_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_pc         <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_imm        <= '0;
         r_rs1_idx    <= '0;
         r_rs2_idx    <= '0;
         r_rd         <= '0;
         r_rd_wen     <= 1'b0;
         r_alu_choice <= '0;
         r_src1_sel   <= '0;
         r_src2_sel   <= '0;
         r_stall_cnt  <= '0;
      end else begin
         // A flushed cycle is not a stall: the held entry is being discarded.
         if (w_stall && !flush)
            r_stall_cnt <= r_stall_cnt + 32'd1;

         if (flush) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_pc         <= in_pc;
            r_rs1        <= w_cap_rs1;
            r_rs2        <= w_cap_rs2;
            r_imm        <= in_imm;
            r_rs1_idx    <= in_rs1_idx;
            r_rs2_idx    <= in_rs2_idx;
            r_rd         <= in_rd;
            r_rd_wen     <= in_rd_wen;
            r_alu_choice <= in_alu_choice;
            r_src1_sel   <= in_src1_sel;
            r_src2_sel   <= in_src2_sel;
         end else begin
            if (w_fire)
               r_valid <= 1'b0;
            if (w_stall && fwd_hit(fwd_wen, fwd_rd, r_rs1_idx))
               r_rs1 <= fwd_data;
            if (w_stall && fwd_hit(fwd_wen, fwd_rd, r_rs2_idx))
               r_rs2 <= fwd_data;
         end
      end
   end

   ysyx_24100029_opsel #(.BW(BW)) u_opsel (
      .i_src1_sel (r_src1_sel),
      .i_src2_sel (r_src2_sel),
      .i_rs1      (r_rs1),
      .i_rs2      (r_rs2),
      .i_pc       (r_pc),
      .i_imm      (r_imm),
      .o_d1       (alu_d1),
      .o_d2       (alu_d2)
   );

   assign out_valid      = r_valid;
   assign out_store_data = r_rs2;
   assign out_alu_choice = r_alu_choice;
   assign out_rd         = r_rd;
   assign out_rd_wen     = r_rd_wen;
   assign out_pc         = r_pc;
   assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_24100029_idex_reg.sv
// Scoreboard bench for the ID/EX register: stimulus pushes expected transfers, a monitor pops them.
module tb_ysyx_24100029_idex_reg;
   import ysyx_24100029_idex_reg_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
   logic        in_rd_wen;
   logic [3:0]  in_alu_choice;
   logic [1:0]  in_src1_sel, in_src2_sel;
   logic        fwd_wen;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] alu_d1, alu_d2, out_store_data, out_pc;
   logic [3:0]  out_alu_choice;
   logic [4:0]  out_rd;
   logic        out_rd_wen;
   logic [31:0] stall_cnt;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] st;
      logic [31:0] pc;
      logic [3:0]  ch;
      logic [4:0]  rd;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   ysyx_24100029_idex_reg #(.BW(32)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .in_alu_choice(in_alu_choice), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
      .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .alu_d1(alu_d1), .alu_d2(alu_d2),
      .out_store_data(out_store_data), .out_alu_choice(out_alu_choice), .out_rd(out_rd),
      .out_rd_wen(out_rd_wen), .out_pc(out_pc), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] i1, input logic [31:0] d1,
                        input logic [4:0] i2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [3:0] ch,
                        input logic [1:0] s1, input logic [1:0] s2);
      in_valid      = 1'b1;
      in_pc         = pc;
      in_rs1_idx    = i1;
      in_rs1_data   = d1;
      in_rs2_idx    = i2;
      in_rs2_data   = d2;
      in_imm        = imm;
      in_rd         = rd;
      in_rd_wen     = 1'b1;
      in_alu_choice = ch;
      in_src1_sel   = s1;
      in_src2_sel   = s2;
   endtask

   task automatic expect_out(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] st,
                             input logic [31:0] pc, input logic [3:0] ch, input logic [4:0] rd);
      exp_t x;
      x.d1 = d1; x.d2 = d2; x.st = st; x.pc = pc; x.ch = ch; x.rd = rd; x.wen = 1'b1;
      sb.push_back(x);
   endtask

   // Monitor: every output transfer must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got transfer pc=0x%0h, expected none", out_pc);
         end else begin
            e = sb.pop_front();
            chk("mon_alu_d1", {32'd0, alu_d1}, {32'd0, e.d1});
            chk("mon_alu_d2", {32'd0, alu_d2}, {32'd0, e.d2});
            chk("mon_store", {32'd0, out_store_data}, {32'd0, e.st});
            chk("mon_pc", {32'd0, out_pc}, {32'd0, e.pc});
            chk("mon_choice", {60'd0, out_alu_choice}, {60'd0, e.ch});
            chk("mon_rd", {59'd0, out_rd}, {59'd0, e.rd});
            chk("mon_rd_wen", {63'd0, out_rd_wen}, {63'd0, e.wen});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; out_ready = 1'b1; flush = 1'b0;
      fwd_wen = 1'b0; fwd_rd = '0; fwd_data = '0;
      issue(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, ALU_ADD, SRC1_RS1, SRC2_RS2);
      in_valid = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("rst_alu_d1", {32'd0, alu_d1}, 64'd0);
      chk("rst_alu_d2", {32'd0, alu_d2}, 64'd0);
      // in_valid ignored while reset is asserted
      issue(32'h44, 5'd1, 32'h9, 5'd2, 32'h9, 32'h9, 5'd1, ALU_SUB, SRC1_PC, SRC2_IMM);
      out_ready = 1'b0;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("rst_ignore_in", {63'd0, out_valid}, 64'd0);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();

      // Basic flow
      issue(32'h100, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd4, ALU_ADD, SRC1_RS1, SRC2_IMM);
      expect_out(32'd5, 32'd7, 32'd9, 32'h100, ALU_ADD, 5'd4);
      tick();
      in_valid = 1'b0;
      chk("basic_valid", {63'd0, out_valid}, 64'd1);
      tick();
      chk("basic_drop", {63'd0, out_valid}, 64'd0);

      // Stall with hold-time forwarding into rs2
      out_ready = 1'b0;
      issue(32'h200, 5'd5, 32'h11, 5'd3, 32'h22, 32'h0, 5'd6, ALU_XOR, SRC1_PC, SRC2_RS2);
      expect_out(32'h200, 32'hDEAD, 32'hDEAD, 32'h200, ALU_XOR, 5'd6);
      tick();
      in_valid = 1'b0;
      chk("stall_c1_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_c1_d2", {32'd0, alu_d2}, 64'h22);
      tick();
      fwd_wen = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hDEAD;
      chk("stall_c2_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      fwd_wen = 1'b0;
      chk("stall_c3_d2", {32'd0, alu_d2}, 64'hDEAD);
      chk("stall_c3_store", {32'd0, out_store_data}, 64'hDEAD);
      chk("stall_c3_d1", {32'd0, alu_d1}, 64'h200);
      chk("stall_c3_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("stall_c4_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      out_ready = 1'b1;
      chk("stall_cnt4", {32'd0, stall_cnt}, 64'd4);
      tick();
      chk("stall_cnt_after", {32'd0, stall_cnt}, 64'd4);
      chk("stall_drop", {63'd0, out_valid}, 64'd0);

      // Capture-time forwarding to both sources
      fwd_wen = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hABCD;
      issue(32'h300, 5'd1, 32'd5, 5'd1, 32'd6, 32'h0, 5'd7, ALU_AND, SRC1_RS1, SRC2_RS2);
      expect_out(32'hABCD, 32'hABCD, 32'hABCD, 32'h300, ALU_AND, 5'd7);
      tick();
      in_valid = 1'b0; fwd_wen = 1'b0;
      tick();

      // x0 is never forwarded
      fwd_wen = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hFFFF;
      issue(32'h400, 5'd0, 32'd0, 5'd0, 32'd0, 32'h55, 5'd8, ALU_OR, SRC1_RS1, SRC2_FOUR);
      expect_out(32'd0, 32'd4, 32'd0, 32'h400, ALU_OR, 5'd8);
      tick();
      in_valid = 1'b0; fwd_wen = 1'b0;
      tick();

      // Flush beats a simultaneous accept, and a flushed stall cycle is not counted
      out_ready = 1'b0;
      issue(32'h600, 5'd9, 32'h1, 5'd10, 32'h2, 32'h3, 5'd9, ALU_SLT, SRC1_RS1, SRC2_RS2);
      tick();
      issue(32'h700, 5'd11, 32'h4, 5'd12, 32'h5, 32'h6, 5'd10, ALU_ADD, SRC1_RS1, SRC2_RS2);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_stall_cnt", {32'd0, stall_cnt}, 64'd4);
      out_ready = 1'b1;
      tick();
      chk("flush_no_late", {63'd0, out_valid}, 64'd0);
      tick();

      // Back-to-back transfers, no bubbles
      issue(32'h500, 5'd13, 32'h10, 5'd14, 32'h20, 32'h30, 5'd7, ALU_ADD, SRC1_ZERO, SRC2_ZERO);
      expect_out(32'h0, 32'h0, 32'h20, 32'h500, ALU_ADD, 5'd7);
      tick();
      chk("b2b_v1", {63'd0, out_valid}, 64'd1);
      issue(32'h504, 5'd13, 32'h11, 5'd14, 32'h21, 32'h31, 5'd8, ALU_SUB, SRC1_ZERO2, SRC2_FOUR);
      expect_out(32'h0, 32'h4, 32'h21, 32'h504, ALU_SUB, 5'd8);
      tick();
      chk("b2b_v2", {63'd0, out_valid}, 64'd1);
      issue(32'h508, 5'd13, 32'h12, 5'd14, 32'h22, 32'h32, 5'd9, ALU_OR, SRC1_RS1, SRC2_IMM);
      expect_out(32'h12, 32'h32, 32'h22, 32'h508, ALU_OR, 5'd9);
      tick();
      in_valid = 1'b0;
      chk("b2b_v3", {63'd0, out_valid}, 64'd1);
      tick();
      chk("b2b_end", {63'd0, out_valid}, 64'd0);

      // Reset during a stall drops the entry
      out_ready = 1'b0;
      issue(32'h800, 5'd15, 32'h7, 5'd16, 32'h8, 32'h9, 5'd11, ALU_ADD, SRC1_RS1, SRC2_RS2);
      expect_out(32'h7, 32'h8, 32'h8, 32'h800, ALU_ADD, 5'd11);
      tick();
      in_valid = 1'b0;
      tick();
      chk("mid_stall_cnt", {32'd0, stall_cnt}, 64'd5);
      reset = 1'b1;
      void'(sb.pop_back());
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      tick(); tick();

      chk("sb_empty", {32'd0, 32'(sb.size())}, 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
